led_dance_sequencer: RTL and testbench

//  Sequences the 5-LED "dance" output: steps a selected 8-step pattern at a prescaled rate.

---
 rtl/led_dance_pkg.sv | 67 ++++++
 rtl/led_dance_sequencer_tick_prescaler.sv | 40 ++++
 rtl/led_dance_sequencer.sv | 166 ++++++++++++++++
 tb/tb_led_dance_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/led_dance_pkg.sv
// led_dance_pkg
//   Shared constants, FSM state encoding and the LED pattern table for the
//   LED dance sequencer.
//   Contents:
//     LED_W, STEPS, STEP_W, PAT_W : vector widths and step count
//     state_t                     : IDLE / RUN / HOLD encoding
//     pat_rom(pat, step)          : LED word for a given pattern and step
package led_dance_pkg;

  localparam int LED_W  = 5;
  localparam int STEPS  = 8;
  localparam int STEP_W = $clog2(STEPS);
  localparam int PAT_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Pattern table, LSB drives led[0].
  function automatic logic [LED_W-1:0] pat_rom(input logic [PAT_W-1:0]  pat,
                                               input logic [STEP_W-1:0] step);
    logic [LED_W-1:0] word;
    case ({pat, step})
      // 0: bounce
      5'b00_000: word = 5'b00001;
      5'b00_001: word = 5'b00010;
      5'b00_010: word = 5'b00100;
      5'b00_011: word = 5'b01000;
      5'b00_100: word = 5'b10000;
      5'b00_101: word = 5'b01000;
      5'b00_110: word = 5'b00100;
      5'b00_111: word = 5'b00010;
      // 1: binary count
      5'b01_000: word = 5'b00000;
      5'b01_001: word = 5'b00001;
      5'b01_010: word = 5'b00010;
      5'b01_011: word = 5'b00011;
      5'b01_100: word = 5'b00100;
      5'b01_101: word = 5'b00101;
      5'b01_110: word = 5'b00110;
      5'b01_111: word = 5'b00111;
      // 2: fill and drain
      5'b10_000: word = 5'b00000;
      5'b10_001: word = 5'b00001;
      5'b10_010: word = 5'b00011;
      5'b10_011: word = 5'b00111;
      5'b10_100: word = 5'b01111;
      5'b10_101: word = 5'b11111;
      5'b10_110: word = 5'b01111;
      5'b10_111: word = 5'b00111;
      // 3: alternate / flash
      5'b11_000: word = 5'b10101;
      5'b11_001: word = 5'b01010;
      5'b11_010: word = 5'b10101;
      5'b11_011: word = 5'b01010;
      5'b11_100: word = 5'b11111;
      5'b11_101: word = 5'b00000;
      5'b11_110: word = 5'b11111;
      5'b11_111: word = 5'b00000;
      default:   word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/led_dance_sequencer_tick_prescaler.sv
// tick_prescaler
//   Step-rate prescaler. Counts 0..TICK_DIV-1 while run is high, freezes the
//   count while run is low, and returns to 0 on clear or reset.
//   Ports:
//     clock : system clock
//     reset : synchronous, active-high reset
//     clear : synchronous return of the count to 0 (has priority over run)
//     run   : 1 = count, 0 = hold
//     tick  : high during the cycle whose count is TICK_DIV-1 (only while run)
module tick_prescaler #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Gated by run so a count frozen at LAST in HOLD does not fire.
  assign tick = run && (count == LAST);

endmodule

// File: rtl/led_dance_sequencer.sv
// led_dance_sequencer
//   Steps one of four 8-step LED patterns at a prescaled rate. Pattern change
//   requests made while running are held until the sequence wraps, so a
//   pattern is never cut mid-run.
//   Ports:
//     clock    : system clock
//     reset    : synchronous, active-high reset
//     enable   : 1 = run/resume stepping, 0 = hold current step
//     stop     : return to IDLE (LEDs off), overrides enable
//     pat_req  : pattern-change request, sampled every cycle
//     pat_sel  : requested pattern index, valid with pat_req
//     pat_ack  : 1-cycle pulse, requested pattern now active
//     led      : registered LED drive
//     step_idx : current step, 0..STEPS-1
//     wrap     : 1-cycle pulse after the step_idx STEPS-1 -> 0 edge
//     busy     : 1 in RUN or HOLD
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | LEDs off, prescaler cleared, pattern requests applied at once
//   RUN   | prescaler counting, step advances on every tick
//   HOLD  | led, step and prescaler count frozen until enable returns
module led_dance_sequencer
  import led_dance_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             stop,
  input  logic             pat_req,
  input  logic [1:0]       pat_sel,
  output logic             pat_ack,
  output logic [LED_W-1:0] led,
  output logic [2:0]       step_idx,
  output logic             wrap,
  output logic             busy
);

  state_t             state, state_nxt;
  logic [LED_W-1:0]   led_nxt;
  logic [STEP_W-1:0]  step_nxt, step_inc;
  logic [PAT_W-1:0]   pat_act, pat_nxt;
  logic               pend_v, pend_v_nxt;
  logic [PAT_W-1:0]   pend_sel, pend_sel_nxt;
  logic [PAT_W-1:0]   start_pat, wrap_pat;
  logic               ack_nxt, wrap_nxt;
  logic               tick;
  logic               pre_clear, pre_run;

  // Clearing in IDLE means the first step after enable gets a full period.
  assign pre_clear = (state == ST_IDLE) || stop;
  assign pre_run   = (state == ST_RUN);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (pre_clear),
    .run   (pre_run),
    .tick  (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      led      <= '0;
      step_idx <= '0;
      pat_act  <= '0;
      pend_v   <= 1'b0;
      pend_sel <= '0;
      pat_ack  <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_nxt;
      led      <= led_nxt;
      step_idx <= step_nxt;
      pat_act  <= pat_nxt;
      pend_v   <= pend_v_nxt;
      pend_sel <= pend_sel_nxt;
      pat_ack  <= ack_nxt;
      wrap     <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    led_nxt      = led;
    step_nxt     = step_idx;
    pat_nxt      = pat_act;
    pend_v_nxt   = pend_v;
    pend_sel_nxt = pend_sel;
    ack_nxt      = 1'b0;
    wrap_nxt     = 1'b0;
    start_pat    = pat_act;
    wrap_pat     = pat_act;
    step_inc     = step_idx + STEP_W'(1);

    if (stop) begin
      // Any pending request is dropped without an ack.
      state_nxt  = ST_IDLE;
      led_nxt    = '0;
      step_nxt   = '0;
      pend_v_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          led_nxt  = '0;
          step_nxt = '0;
          if (pat_req) begin
            pat_nxt   = pat_sel;
            ack_nxt   = 1'b1;
            start_pat = pat_sel;
          end
          if (enable) begin
            state_nxt = ST_RUN;
            led_nxt   = pat_rom(start_pat, STEP_W'(0));
          end
        end

        ST_RUN: begin
          if (pat_req) begin
            pend_v_nxt   = 1'b1;
            pend_sel_nxt = pat_sel;
          end
          if (tick) begin
            step_nxt = step_inc;
            if (step_idx == STEP_W'(STEPS - 1)) begin
              wrap_nxt = 1'b1;
              // A request in the wrap cycle itself is the latest one.
              if (pat_req || pend_v) begin
                wrap_pat   = pat_req ? pat_sel : pend_sel;
                pat_nxt    = wrap_pat;
                ack_nxt    = 1'b1;
                pend_v_nxt = 1'b0;
              end
            end
            led_nxt = pat_rom(wrap_pat, step_inc);
          end
          if (!enable) begin
            state_nxt = ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (pat_req) begin
            pend_v_nxt   = 1'b1;
            pend_sel_nxt = pat_sel;
          end
          if (enable) begin
            state_nxt = ST_RUN;
          end
        end

        default: begin
          state_nxt = ST_IDLE;
          led_nxt   = '0;
          step_nxt  = '0;
        end
      endcase
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_HOLD);

endmodule

// File: tb/tb_led_dance_sequencer.sv
module tb_led_dance_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       stop = 1'b0;
  logic       pat_req = 1'b0;
  logic [1:0] pat_sel = 2'd0;
  logic       pat_ack;
  logic [4:0] led;
  logic [2:0] step_idx;
  logic       wrap;
  logic       busy;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] EXP [4][8] = '{
    '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000, 5'b00100, 5'b00010},
    '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111},
    '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b01111, 5'b00111},
    '{5'b10101, 5'b01010, 5'b10101, 5'b01010, 5'b11111, 5'b00000, 5'b11111, 5'b00000}
  };

  led_dance_sequencer #(.TICK_DIV(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .stop     (stop),
    .pat_req  (pat_req),
    .pat_sel  (pat_sel),
    .pat_ack  (pat_ack),
    .led      (led),
    .step_idx (step_idx),
    .wrap     (wrap),
    .busy     (busy)
  );

  always #10 clock = ~clock;

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench 1 ns after the edge that enters RUN with pattern 0.
  task automatic start_run();
    reset = 1'b1; enable = 1'b0; stop = 1'b0; pat_req = 1'b0; pat_sel = 2'd0;
    adv();
    reset = 1'b0; enable = 1'b1;
    adv();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; stop = 1'b0; pat_req = 1'b0;
    adv(); adv();
    checks++; if (led !== 5'b00000) begin errors++; $display("FAIL reset_led got=%b exp=00000", led); end
    checks++; if (step_idx !== 3'd0) begin errors++; $display("FAIL reset_step got=%0d exp=0", step_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (pat_ack !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL reset_pulses ack=%b wrap=%b exp=0/0", pat_ack, wrap); end
    reset = 1'b0;
    repeat (5) adv();
    checks++; if (led !== 5'b00000 || busy !== 1'b0) begin errors++; $display("FAIL idle_before_enable led=%b busy=%b exp=00000/0", led, busy); end
  endtask

  task automatic test_walk();
    int wraps;
    wraps = 0;
    start_run();
    for (int i = 0; i < 64; i++) begin
      checks++; if (led !== EXP[0][(i/4)%8]) begin errors++; $display("FAIL walk_led c=%0d got=%b exp=%b", i, led, EXP[0][(i/4)%8]); end
      checks++; if (step_idx !== 3'((i/4)%8)) begin errors++; $display("FAIL walk_step c=%0d got=%0d exp=%0d", i, step_idx, (i/4)%8); end
      checks++; if (wrap !== (i == 32)) begin errors++; $display("FAIL walk_wrap c=%0d got=%b exp=%b", i, wrap, (i == 32)); end
      checks++; if (pat_ack !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL walk_ack_busy c=%0d ack=%b busy=%b exp=0/1", i, pat_ack, busy); end
      if (wrap === 1'b1) wraps++;
      adv();
    end
    checks++; if (wraps != 1) begin errors++; $display("FAIL walk_wrap_count got=%0d exp=1", wraps); end
  endtask

  task automatic test_pattern_change();
    start_run();
    repeat (13) adv();
    pat_req = 1'b1; pat_sel = 2'd3;
    adv();
    pat_req = 1'b0;
    for (int i = 14; i < 32; i++) begin
      checks++; if (led !== EXP[0][i/4] || pat_ack !== 1'b0) begin errors++; $display("FAIL chg_pre c=%0d led=%b ack=%b exp=%b/0", i, led, pat_ack, EXP[0][i/4]); end
      adv();
    end
    checks++; if (led !== 5'b10101 || step_idx !== 3'd0) begin errors++; $display("FAIL chg_wrap_led led=%b step=%0d exp=10101/0", led, step_idx); end
    checks++; if (pat_ack !== 1'b1 || wrap !== 1'b1) begin errors++; $display("FAIL chg_wrap_pulse ack=%b wrap=%b exp=1/1", pat_ack, wrap); end
    adv();
    checks++; if (pat_ack !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL chg_pulse_len ack=%b wrap=%b exp=0/0", pat_ack, wrap); end
    repeat (3) adv();
    checks++; if (led !== 5'b01010 || step_idx !== 3'd1) begin errors++; $display("FAIL chg_new_step1 led=%b step=%0d exp=01010/1", led, step_idx); end
  endtask

  task automatic test_hold();
    start_run();
    repeat (20) adv();
    checks++; if (led !== 5'b01000 || step_idx !== 3'd5) begin errors++; $display("FAIL hold_entry led=%b step=%0d exp=01000/5", led, step_idx); end
    enable = 1'b0;
    for (int i = 21; i <= 30; i++) begin
      adv();
      checks++; if (led !== 5'b01000 || step_idx !== 3'd5 || busy !== 1'b1) begin errors++; $display("FAIL hold_frozen c=%0d led=%b step=%0d busy=%b exp=01000/5/1", i, led, step_idx, busy); end
    end
    enable = 1'b1;
    for (int i = 31; i <= 33; i++) begin
      adv();
      checks++; if (led !== 5'b01000 || step_idx !== 3'd5) begin errors++; $display("FAIL hold_resume c=%0d led=%b step=%0d exp=01000/5", i, led, step_idx); end
    end
    adv();
    checks++; if (led !== 5'b00100 || step_idx !== 3'd6) begin errors++; $display("FAIL hold_step6 led=%b step=%0d exp=00100/6", led, step_idx); end
  endtask

  task automatic test_stop();
    start_run();
    repeat (17) adv();
    stop = 1'b1;
    adv();
    checks++; if (led !== 5'b00000 || step_idx !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL stop_idle led=%b step=%0d busy=%b exp=00000/0/0", led, step_idx, busy); end
    adv();
    checks++; if (busy !== 1'b0 || led !== 5'b00000) begin errors++; $display("FAIL stop_priority led=%b busy=%b exp=00000/0", led, busy); end
    stop = 1'b0;
    adv();
    checks++; if (led !== 5'b00001 || step_idx !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL stop_restart led=%b step=%0d busy=%b exp=00001/0/1", led, step_idx, busy); end
    repeat (3) adv();
    checks++; if (step_idx !== 3'd0) begin errors++; $display("FAIL stop_full_period step=%0d exp=0", step_idx); end
    adv();
    checks++; if (led !== 5'b00010 || step_idx !== 3'd1) begin errors++; $display("FAIL stop_step1 led=%b step=%0d exp=00010/1", led, step_idx); end
  endtask

  task automatic test_reset_pending();
    start_run();
    repeat (9) adv();
    pat_req = 1'b1; pat_sel = 2'd2;
    adv();
    pat_req = 1'b0;
    repeat (2) adv();
    reset = 1'b1;
    adv();
    checks++; if (led !== 5'b00000 || step_idx !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstrun_state led=%b step=%0d busy=%b exp=00000/0/0", led, step_idx, busy); end
    checks++; if (pat_ack !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL rstrun_pulses ack=%b wrap=%b exp=0/0", pat_ack, wrap); end
    reset = 1'b0;
    adv();
    for (int i = 0; i <= 36; i++) begin
      checks++; if (pat_ack !== 1'b0) begin errors++; $display("FAIL rstrun_no_ack c=%0d got=%b exp=0", i, pat_ack); end
      checks++; if (led !== EXP[0][(i/4)%8]) begin errors++; $display("FAIL rstrun_pat0 c=%0d got=%b exp=%b", i, led, EXP[0][(i/4)%8]); end
      adv();
    end
  endtask

  task automatic test_latest_wins();
    start_run();
    repeat (5) adv();
    pat_req = 1'b1; pat_sel = 2'd3;
    adv();
    pat_req = 1'b0;
    repeat (14) adv();
    pat_req = 1'b1; pat_sel = 2'd1;
    adv();
    pat_req = 1'b0;
    repeat (11) adv();
    checks++; if (led !== 5'b00000 || pat_ack !== 1'b1 || wrap !== 1'b1) begin errors++; $display("FAIL latest_wrap led=%b ack=%b wrap=%b exp=00000/1/1", led, pat_ack, wrap); end
    repeat (4) adv();
    checks++; if (led !== 5'b00001) begin errors++; $display("FAIL latest_step1 got=%b exp=00001", led); end
  endtask

  task automatic test_back_to_back();
    reset = 1'b1; enable = 1'b0; stop = 1'b0; pat_req = 1'b0;
    adv();
    reset = 1'b0;
    pat_req = 1'b1; pat_sel = 2'd2;
    adv();
    checks++; if (pat_ack !== 1'b1) begin errors++; $display("FAIL idle_ack1 got=%b exp=1", pat_ack); end
    pat_sel = 2'd1;
    adv();
    checks++; if (pat_ack !== 1'b1) begin errors++; $display("FAIL idle_ack2 got=%b exp=1", pat_ack); end
    pat_req = 1'b0;
    adv();
    checks++; if (pat_ack !== 1'b0 || led !== 5'b00000 || busy !== 1'b0) begin errors++; $display("FAIL idle_after led=%b ack=%b busy=%b exp=00000/0/0", led, pat_ack, busy); end
    enable = 1'b1;
    adv();
    for (int i = 0; i < 31; i++) begin
      checks++; if (led !== EXP[1][i/4]) begin errors++; $display("FAIL idle_pat1 c=%0d got=%b exp=%b", i, led, EXP[1][i/4]); end
      adv();
    end
    pat_req = 1'b1; pat_sel = 2'd3;
    adv();
    pat_req = 1'b0;
    checks++; if (led !== 5'b10101 || pat_ack !== 1'b1 || wrap !== 1'b1) begin errors++; $display("FAIL wrap_coincide led=%b ack=%b wrap=%b exp=10101/1/1", led, pat_ack, wrap); end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_pattern_change();
    test_hold();
    test_stop();
    test_reset_pending();
    test_latest_wins();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
